// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state type, busy-flag bit position and timing
// defaults for the HD44780-style read engine.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EHIGH   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } lcd_state_e;

  localparam int BF_BIT        = 7;
  localparam int TMR_W         = 16;

  localparam int DEF_SETUP_CYC = 3;
  localparam int DEF_EHIGH_CYC = 12;
  localparam int DEF_HOLD_CYC  = 2;
  localparam int DEF_ELOW_CYC  = 13;
  localparam int DEF_MAX_POLLS = 255;

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter; o_done marks the last
// cycle of the phase that was loaded with (length - 1).
module lcd_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-cycle sequencer with optional busy-flag
// polling limit (enable with LCD_READER_TIMEOUT_EN).
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int EHIGH_CYC = DEF_EHIGH_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int ELOW_CYC  = DEF_ELOW_CYC,
  parameter int MAX_POLLS = DEF_MAX_POLLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll_bf,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       bus_own,
  output logic       busy,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       timeout
);

  lcd_state_e       r_state;
  lcd_state_e       w_next;
  logic             r_rs_lat;
  logic             r_poll_lat;
  logic             w_accept;
  logic             w_bf_wait;
  logic             w_finish;
  logic             w_tdone;
  logic             w_load;
  logic [TMR_W-1:0] w_tval;
  logic             w_own_nxt;
  logic             w_e_nxt;
  logic             w_rs_nxt;
  logic             w_sample;
  logic             r_e;
  logic             r_own;
  logic             r_rs_o;
  logic             r_valid;
  logic [7:0]       r_rd_data;

`ifdef LCD_READER_TIMEOUT_EN
  localparam int PW = $clog2(MAX_POLLS + 1);
  logic [PW-1:0] r_polls;
  logic          w_poll_last;
  logic          w_repoll;
  logic          w_tout;
  logic          r_tout;
`endif

  assign w_accept  = (r_state == ST_IDLE) & req;
  assign w_bf_wait = r_poll_lat & r_rd_data[BF_BIT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_finish = 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
    w_repoll = 1'b0;
    w_tout   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE:    if (req) w_next = ST_SETUP;
      ST_SETUP:   if (w_tdone) w_next = ST_EHIGH;
      ST_EHIGH:   if (w_tdone) w_next = ST_HOLD;
      ST_HOLD:    if (w_tdone) w_next = ST_RECOVER;
      ST_RECOVER: if (w_tdone) begin
        if (!w_bf_wait) begin
          w_next   = ST_IDLE;
          w_finish = 1'b1;
        end
`ifdef LCD_READER_TIMEOUT_EN
        else if (w_poll_last) begin
          w_next   = ST_IDLE;
          w_finish = 1'b1;
          w_tout   = 1'b1;
        end else begin
          w_next   = ST_SETUP;
          w_repoll = 1'b1;
        end
`else
        else w_next = ST_SETUP;
`endif
      end
      default:    w_next = ST_IDLE;
    endcase
  end

  // Every state change reloads the timer with the new phase length.
  assign w_load = (w_next != r_state);

  always_comb begin
    w_tval = '0;
    unique case (w_next)
      ST_SETUP:   w_tval = TMR_W'(SETUP_CYC - 1);
      ST_EHIGH:   w_tval = TMR_W'(EHIGH_CYC - 1);
      ST_HOLD:    w_tval = TMR_W'(HOLD_CYC - 1);
      ST_RECOVER: w_tval = TMR_W'(ELOW_CYC - 1);
      default:    w_tval = '0;
    endcase
  end

  lcd_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_val  (w_tval),
    .o_done (w_tdone)
  );

  always_comb begin
    w_own_nxt = (w_next != ST_IDLE);
    w_e_nxt   = (w_next == ST_EHIGH);
    w_rs_nxt  = w_own_nxt & (w_accept ? rs_sel : r_rs_lat);
    w_sample  = (r_state == ST_EHIGH) & w_tdone;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs_lat   <= 1'b0;
      r_poll_lat <= 1'b0;
    end else if (w_accept) begin
      r_rs_lat   <= rs_sel;
      r_poll_lat <= poll_bf & ~rs_sel;
    end
  end

  // Pin drives are flops fed from the next state so E never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e       <= 1'b0;
      r_own     <= 1'b0;
      r_rs_o    <= 1'b0;
      r_valid   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_e     <= w_e_nxt;
      r_own   <= w_own_nxt;
      r_rs_o  <= w_rs_nxt;
      r_valid <= w_finish;
      if (w_sample) r_rd_data <= lcd_data_in;
    end
  end

`ifdef LCD_READER_TIMEOUT_EN
  assign w_poll_last = (int'(r_polls) + 1 >= MAX_POLLS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_polls <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_tout <= w_tout;
      if (w_accept) r_polls <= '0;
      else if (w_repoll) r_polls <= r_polls + PW'(1);
    end
  end

  assign timeout = r_tout;
`else
  assign timeout = 1'b0;
`endif

  assign lcd_e    = r_e;
  assign lcd_rw   = r_own;
  assign lcd_rs   = r_rs_o;
  assign bus_own  = r_own;
  assign busy     = r_own;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_valid;

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: vector table, hand sequences and random reads
// checked against a read-count/latency model of the LCD reader.
module tb_lcd_reader;

  localparam int SETUP = 3;
  localparam int EHIGH = 12;
  localparam int HOLD  = 2;
  localparam int ELOW  = 13;
  localparam int PER   = SETUP + EHIGH + HOLD + ELOW;
  localparam int MAXP  = 4;
`ifdef LCD_READER_TIMEOUT_EN
  localparam int KMAX  = 5;
`else
  localparam int KMAX  = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       rs_sel = 1'b0;
  logic       poll_bf = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic       lcd_rs, lcd_rw, lcd_e, bus_own, busy;
  logic [7:0] rd_data;
  logic       rd_valid, timeout;

  lcd_reader #(
    .SETUP_CYC (SETUP),
    .EHIGH_CYC (EHIGH),
    .HOLD_CYC  (HOLD),
    .ELOW_CYC  (ELOW),
    .MAX_POLLS (MAXP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .rs_sel      (rs_sel),
    .poll_bf     (poll_bf),
    .lcd_data_in (lcd_data_in),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .bus_own     (bus_own),
    .busy        (busy),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit g_pending = 1'b0;

  typedef logic [7:0] bytes_t [8];

  typedef struct {
    bit         rs;
    bit         poll;
    int         nbf;
    logic [7:0] last;
    int         xn;
    logic [7:0] xd;
    bit         xt;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bytes_t mk(input int nbf, input logic [7:0] last);
    bytes_t d;
    for (int i = 0; i < 8; i++) d[i] = (i < nbf) ? 8'h80 : last;
    return d;
  endfunction

  // Reads stop at the first sample with BF clear (or at the poll limit).
  function automatic void model(input bit rs, input bit poll,
                                input bytes_t d, output int n,
                                output logic [7:0] xd, output bit xt);
    n  = 1;
    xt = 1'b0;
    if (!rs && poll) begin
      for (int i = 0; i < 8; i++) begin
        n = i + 1;
        if (!d[i][7]) break;
`ifdef LCD_READER_TIMEOUT_EN
        if (n == MAXP) begin
          xt = 1'b1;
          break;
        end
`endif
      end
    end
    xd = d[n-1];
  endfunction

  task automatic run_txn(input string name, input bit rs, input bit poll,
                         input bytes_t d, input int n,
                         input logic [7:0] xd, input bit xt,
                         input bit chain);
    int   total;
    bit   bad;
    logic ee, eb, ev;
    total = PER * n;
    bad   = 1'b0;
    if (!g_pending) begin
      req         = 1'b1;
      rs_sel      = rs;
      poll_bf     = poll;
      lcd_data_in = d[0];
    end
    g_pending = 1'b0;
    for (int t = 0; t <= total; t++) begin
      @(posedge clk);
      #1;
      eb = (t < total);
      ev = (t == total);
      ee = eb && ((t % PER) >= SETUP) && ((t % PER) < SETUP + EHIGH);
      if (!bad && (lcd_e !== ee || busy !== eb || bus_own !== eb ||
                   lcd_rw !== eb || lcd_rs !== (eb & rs) ||
                   rd_valid !== ev)) begin
        bad = 1'b1;
        $display("FAIL %s trace t=%0d e,busy,own,rw,rs,valid got %b%b%b%b%b%b expected %b%b%b%b%b%b",
                 name, t, lcd_e, busy, bus_own, lcd_rw, lcd_rs, rd_valid,
                 ee, eb, eb, eb, eb & rs, ev);
      end
      if (t < total) begin
        req         = 1'($urandom);
        rs_sel      = 1'($urandom);
        poll_bf     = 1'($urandom);
        lcd_data_in = d[t / PER];
      end
    end
    tests++;
    if (bad) fails++;
    chk({name, " rd_data"}, 32'(rd_data), 32'(xd));
    chk({name, " timeout"}, 32'(timeout), 32'(xt));
    if (chain) begin
      req         = 1'b1;
      rs_sel      = rs;
      poll_bf     = poll;
      lcd_data_in = d[0];
      g_pending   = 1'b1;
    end else begin
      req     = 1'b0;
      rs_sel  = 1'b0;
      poll_bf = 1'b0;
    end
  endtask

  vec_t   vt [6];
  bytes_t bd;

  initial begin
    vt[0] = '{1'b1, 1'b0, 0, 8'h41, 1, 8'h41, 1'b0};
    vt[1] = '{1'b0, 1'b1, 3, 8'h05, 4, 8'h05, 1'b0};
    vt[2] = '{1'b1, 1'b1, 2, 8'h33, 1, 8'h80, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1, 8'h12, 1, 8'h80, 1'b0};
    vt[4] = '{1'b0, 1'b1, 0, 8'h7F, 1, 8'h7F, 1'b0};
`ifdef LCD_READER_TIMEOUT_EN
    vt[5] = '{1'b0, 1'b1, 6, 8'h00, 4, 8'h80, 1'b1};
`else
    vt[5] = '{1'b0, 1'b1, 1, 8'h3C, 2, 8'h3C, 1'b0};
`endif

    step();
    step();
    chk("reset lcd_e", 32'(lcd_e), 0);
    chk("reset lcd_rw", 32'(lcd_rw), 0);
    chk("reset lcd_rs", 32'(lcd_rs), 0);
    chk("reset bus_own", 32'(bus_own), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset timeout", 32'(timeout), 0);
    chk("reset rd_data", 32'(rd_data), 0);
    reset = 1'b1;
    step();
    step();

    for (int v = 0; v < 6; v++) begin
      bd = mk(vt[v].nbf, vt[v].last);
      run_txn($sformatf("vec%0d", v), vt[v].rs, vt[v].poll, bd,
              vt[v].xn, vt[v].xd, vt[v].xt, 1'b0);
      step();
    end

    bd = mk(0, 8'h41);
    run_txn("chain first", 1'b1, 1'b0, bd, 1, 8'h41, 1'b0, 1'b1);
    bd = mk(0, 8'h6B);
    run_txn("chain second", 1'b1, 1'b0, bd, 1, 8'h6B, 1'b0, 1'b0);

    begin : reset_abort
      bit e_seen, v_seen;
      req         = 1'b1;
      rs_sel      = 1'b1;
      poll_bf     = 1'b0;
      lcd_data_in = 8'h5A;
      step();
      req = 1'b0;
      repeat (8) step();
      chk("abort pre lcd_e", 32'(lcd_e), 1);
      #2 reset = 1'b0;
      #1;
      chk("abort async lcd_e", 32'(lcd_e), 0);
      chk("abort async busy", 32'(busy), 0);
      chk("abort async bus_own", 32'(bus_own), 0);
      step();
      step();
      chk("abort rd_valid", 32'(rd_valid), 0);
      chk("abort rd_data", 32'(rd_data), 0);
      reset  = 1'b1;
      e_seen = 1'b0;
      v_seen = 1'b0;
      repeat (40) begin
        step();
        e_seen |= lcd_e;
        v_seen |= rd_valid;
      end
      chk("abort no E", 32'(e_seen), 0);
      chk("abort no rd_valid", 32'(v_seen), 0);
      bd = mk(0, 8'hC3);
      run_txn("after abort", 1'b1, 1'b0, bd, 1, 8'hC3, 1'b0, 1'b0);
    end

`ifndef LCD_READER_TIMEOUT_EN
    begin : poll_forever
      int   pulses;
      bit   v_seen, found;
      logic prev_e;
      req         = 1'b1;
      rs_sel      = 1'b0;
      poll_bf     = 1'b1;
      lcd_data_in = 8'h80;
      step();
      req    = 1'b0;
      pulses = 0;
      v_seen = 1'b0;
      prev_e = lcd_e;
      for (int t = 1; t < 10 * PER; t++) begin
        step();
        if (lcd_e && !prev_e) pulses++;
        prev_e = lcd_e;
        v_seen |= rd_valid;
      end
      chk("poll10 E pulses", 32'(pulses), 10);
      chk("poll10 busy", 32'(busy), 1);
      chk("poll10 timeout", 32'(timeout), 0);
      chk("poll10 no rd_valid", 32'(v_seen), 0);
      lcd_data_in = 8'h00;
      found = 1'b0;
      for (int t = 0; t < 2 * PER && !found; t++) begin
        step();
        found = rd_valid;
      end
      chk("poll exit rd_valid", 32'(found), 1);
      chk("poll exit rd_data", 32'(rd_data), 0);
    end
`endif

    for (int r = 0; r < 20; r++) begin : rnd
      int         k, n, g;
      bit         rs, poll, xt;
      logic [7:0] xd;
      bytes_t     d;
      rs   = 1'($urandom);
      poll = 1'($urandom);
      k    = $urandom_range(0, KMAX);
      for (int i = 0; i < 8; i++) begin
        d[i] = 8'($urandom);
        if (i < k) d[i][7] = 1'b1;
        else if (i == k) d[i][7] = 1'b0;
      end
      model(rs, poll, d, n, xd, xt);
      run_txn($sformatf("rand%0d", r), rs, poll, d, n, xd, xt, 1'b0);
      g = $urandom_range(0, 3);
      repeat (g) step();
      chk($sformatf("rand%0d hold", r), 32'(rd_data), 32'(xd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 3, meaning RS/RW-to-E-rise setup in clk cycles (60 ns at 50 MHz).
REQ-002 SHALL have parameter EHIGH_CYC, default 12, meaning E high width in cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 2, meaning RS/RW hold after E fall in cycles.
REQ-004 SHALL have parameter ELOW_CYC, default 13, meaning E low recovery before the next cycle or release.
REQ-005 SHALL have parameter MAX_POLLS, default 255, meaning the busy-flag poll limit (used only with the timeout feature).
REQ-006 SHALL have port clk, input, 1, the 50 MHz clock.
REQ-007 SHALL have port reset, input, 1, the reset: asynchronous, active-low.
REQ-008 SHALL have port req, input, 1, a read request sampled only in IDLE.
REQ-009 SHALL have port rs_sel, input, 1, selecting the register: 0 = busy flag/address, 1 = DDRAM/CGRAM data.
REQ-010 SHALL have port poll_bf, input, 1, which repeats status reads until BF=0 (honoured only when rs_sel=0).
REQ-011 SHALL have port lcd_data_in, input, 8, the sampled LCD data bus.
REQ-012 SHALL have port lcd_rs, output, 1, the LCD register select.
REQ-013 SHALL have port lcd_rw, output, 1, the LCD read/write select (1 = read).
REQ-014 SHALL have port lcd_e, output, 1, the LCD enable.
REQ-015 SHALL have port bus_own, output, 1, which is high while the reader owns RS/RW/E; the top tristates lcd_data while it is high.
REQ-016 SHALL have port busy, output, 1, which is high from acceptance until completion.
REQ-017 SHALL have port rd_data, output, 8, the last byte read.
REQ-018 SHALL have port rd_valid, output, 1, a one-cycle completion pulse.
REQ-019 SHALL have port timeout, output, 1, which is valid with rd_valid and indicates the poll limit was hit.

Function
REQ-020 SHALL implement states IDLE, SETUP, EHIGH, HOLD, RECOVER.
- IDLE->SETUP on req=1.
- SETUP->EHIGH after SETUP_CYC cycles.
- EHIGH->HOLD after EHIGH_CYC cycles.
- HOLD->RECOVER after HOLD_CYC cycles.
- RECOVER->SETUP (re-poll) or RECOVER->IDLE after ELOW_CYC cycles.
REQ-021 SHALL latch rs_sel and poll_bf on the accepting edge; input changes during the transaction SHALL be ignored.
REQ-022 SHALL drive lcd_rw=1 and lcd_rs=latched rs_sel in SETUP, EHIGH, HOLD and RECOVER, and lcd_rw=0, lcd_rs=0 in IDLE.
REQ-023 SHALL drive lcd_e=1 only in EHIGH, registered and glitch-free.
REQ-024 SHALL sample lcd_data_in into rd_data on the last EHIGH cycle, i.e. before E falls.
REQ-025 SHALL hold bus_own and busy high in every non-IDLE state.
REQ-026 SHALL, for a single read, pulse rd_valid exactly SETUP_CYC+EHIGH_CYC+HOLD_CYC+ELOW_CYC edges after the accepting edge (30 with defaults), in the same cycle busy falls.
REQ-027 SHALL, when latched poll_bf=1 and rs_sel=0, re-enter SETUP if the sampled bit 7 (BF) =1; otherwise it SHALL complete.
REQ-028 SHALL ignore req while busy; no queuing.
REQ-029 SHALL accept req asserted in the rd_valid cycle on the next edge, since the state is already IDLE.
REQ-030 SHALL keep rd_data stable between rd_valid pulses.

Reset
REQ-031 SHALL, on reset low, asynchronously force: state IDLE; lcd_e=0, lcd_rw=0, lcd_rs=0, bus_own=0, busy=0, rd_valid=0, timeout=0, rd_data=8'h00; poll and phase counters cleared.
REQ-032 SHALL abort a transaction in progress on mid-transaction reset with no rd_valid, and SHALL NOT drive E high again until a new req after reset release.

Configuration
REQ-033 SHALL, with LCD_READER_TIMEOUT_EN defined, count polls; once MAX_POLLS status reads have all returned BF=1, it SHALL complete with rd_valid=1, timeout=1, and rd_data= the last sample.
REQ-034 SHALL, without LCD_READER_TIMEOUT_EN, poll indefinitely, omit the poll counter, and tie timeout to 0.

Structure
REQ-035 SHALL place the state enum, BF bit index (7) and default timing constants in shared package lcd_pkg.
REQ-036 SHALL implement phase timing with one sub-module, lcd_phase_timer: a loadable down-counter with a terminal pulse, reused for all four phases.

Verification
REQ-037 SHALL cover: req=1, rs_sel=1, data bus=8'h41 -> lcd_rw=1, lcd_rs=1, E high 12 cycles, rd_data=8'h41, rd_valid at edge 30.
REQ-038 SHALL cover: req, rs_sel=0, poll_bf=1, BF=1 for 3 reads then bus=8'h05 -> 4 E pulses, rd_data=8'h05, rd_valid at edge 120.
REQ-039 SHALL cover: reset low during EHIGH -> lcd_e=0 asynchronously, busy=0, no rd_valid; next req restarts cleanly.
REQ-040 SHALL cover: req pulses during busy -> ignored; req in the rd_valid cycle -> a new transaction starts next edge.
REQ-041 SHALL cover, with LCD_READER_TIMEOUT_EN and MAX_POLLS=4: bus held 8'h80 -> 4 reads, rd_valid with timeout=1, rd_data=8'h80.
REQ-042 SHALL cover, without the macro: the same stimulus for 10 reads -> still busy, timeout=0.
